// File: rtl/ring_output_port.sv
// Ring output port: two phase-alternating one-entry slots feeding the next router.
// The fill VC is arbitrated between the upstream ring and the local PE each cycle.
module ring_output_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        polarity,
  input  logic        ring_si,
  input  logic [63:0] ring_di,
  output logic        ring_ri,
  input  logic        pe_so,
  input  logic [63:0] pe_di_even,
  input  logic [63:0] pe_di_odd,
  output logic        pe_ro,
  output logic        pe_wr_en,
  output logic        link_so,
  output logic [63:0] link_do,
  input  logic        link_ri,
  output logic [15:0] inj_cnt
);

  logic [63:0] slot_even_q, slot_even_d;
  logic [63:0] slot_odd_q, slot_odd_d;
  logic        full_even_q, full_even_d;
  logic        full_odd_q, full_odd_d;
  logic        rr_even_q, rr_even_d;
  logic        rr_odd_q, rr_odd_d;
  logic [15:0] inj_cnt_q, inj_cnt_d;

  logic        full_f;
  logic        full_t;
  logic        rr_f;
  logic [63:0] data_t;
  logic        ring_req;
  logic        pe_req;
  logic [63:0] pe_data;
  logic        ring_gnt;
  logic        pe_gnt;
  logic [63:0] wr_data;
  logic        link_fire;

  // Fill VC is polarity itself; the transmit VC is always the other slot.
  assign full_f   = polarity ? full_odd_q : full_even_q;
  assign full_t   = polarity ? full_even_q : full_odd_q;
  assign rr_f     = polarity ? rr_odd_q : rr_even_q;
  assign data_t   = polarity ? slot_even_q : slot_odd_q;

  assign ring_req = ring_si && (ring_di[63] == polarity);
  assign pe_req   = pe_so;
  assign pe_data  = polarity ? pe_di_odd : pe_di_even;

  // rr_f = 0 favours the ring, 1 favours the PE when both request.
  assign ring_gnt  = !full_f && ring_req && (!pe_req || !rr_f);
  assign pe_gnt    = !full_f && pe_req && (!ring_req || rr_f);
  assign wr_data   = pe_gnt ? pe_data : ring_di;
  assign link_fire = full_t && link_ri;

  always_comb begin
    slot_even_d = slot_even_q;
    slot_odd_d  = slot_odd_q;
    full_even_d = full_even_q;
    full_odd_d  = full_odd_q;
    rr_even_d   = rr_even_q;
    rr_odd_d    = rr_odd_q;
    inj_cnt_d   = inj_cnt_q;

    if (ring_gnt || pe_gnt) begin
      if (polarity) begin
        slot_odd_d = wr_data;
        full_odd_d = 1'b1;
      end else begin
        slot_even_d = wr_data;
        full_even_d = 1'b1;
      end
    end

    // After a contended grant the loser gets priority next time.
    if (ring_req && pe_req && !full_f) begin
      if (polarity) rr_odd_d = ring_gnt;
      else          rr_even_d = ring_gnt;
    end

    // Transmit slot is never the fill slot, so these cannot collide.
    if (link_fire) begin
      if (polarity) full_even_d = 1'b0;
      else          full_odd_d  = 1'b0;
    end

    if (pe_gnt && (inj_cnt_q != 16'hFFFF)) inj_cnt_d = inj_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_even_q <= 64'h0;
      slot_odd_q  <= 64'h0;
      full_even_q <= 1'b0;
      full_odd_q  <= 1'b0;
      rr_even_q   <= 1'b0;
      rr_odd_q    <= 1'b0;
      inj_cnt_q   <= 16'h0;
    end else begin
      slot_even_q <= slot_even_d;
      slot_odd_q  <= slot_odd_d;
      full_even_q <= full_even_d;
      full_odd_q  <= full_odd_d;
      rr_even_q   <= rr_even_d;
      rr_odd_q    <= rr_odd_d;
      inj_cnt_q   <= inj_cnt_d;
    end
  end

  assign ring_ri  = !full_f && !(pe_req && rr_f);
  assign pe_ro    = !full_f;
  assign pe_wr_en = pe_gnt;
  assign link_so  = link_fire;
  assign link_do  = full_t ? data_t : 64'h0;
  assign inj_cnt  = inj_cnt_q;

endmodule

// File: tb/tb_ring_output_port.sv
// Directed bench for ring_output_port: expected link packets go into a queue
// that an independent monitor drains whenever link_so is seen.
module tb_ring_output_port;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic        ring_si;
  logic [63:0] ring_di;
  logic        ring_ri;
  logic        pe_so;
  logic [63:0] pe_di_even;
  logic [63:0] pe_di_odd;
  logic        pe_ro;
  logic        pe_wr_en;
  logic        link_so;
  logic [63:0] link_do;
  logic        link_ri;
  logic [15:0] inj_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] PE_EVEN = 64'h0000_0000_E0E0_E0E0;
  localparam logic [63:0] PE_ODD  = 64'h8000_0000_0D0D_0D0D;

  ring_output_port dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .ring_si(ring_si), .ring_di(ring_di), .ring_ri(ring_ri),
    .pe_so(pe_so), .pe_di_even(pe_di_even), .pe_di_odd(pe_di_odd),
    .pe_ro(pe_ro), .pe_wr_en(pe_wr_en),
    .link_so(link_so), .link_do(link_do), .link_ri(link_ri),
    .inj_cnt(inj_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic pol, input logic rsi, input logic [63:0] rdi,
                       input logic pso, input logic lri);
    polarity = pol;
    ring_si  = rsi;
    ring_di  = rdi;
    pe_so    = pso;
    link_ri  = lri;
  endtask

  // Monitor: every link transfer must match the oldest expected packet.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && link_so) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL link_unexpected: got link_do %h expected no transfer", link_do);
        end else begin
          e = exp_q.pop_front();
          check("link_do", link_do, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    pe_di_even = PE_EVEN;
    pe_di_odd  = PE_ODD;
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("rst_ring_ri", ring_ri, 1);
    check("rst_pe_ro", pe_ro, 1);
    check("rst_link_so", link_so, 0);
    check("rst_link_do", link_do, 0);
    check("rst_pe_wr_en", pe_wr_en, 0);
    check("rst_inj_cnt", inj_cnt, 0);

    // Ring packet into even slot, transmitted on the next phase.
    tick(); drive(1'b0, 1'b1, 64'h0000_0000_0000_00A5, 1'b0, 1'b1); #1;
    check("a_ring_ri", ring_ri, 1);
    check("a_pe_wr_en", pe_wr_en, 0);
    exp_q.push_back(64'h0000_0000_0000_00A5);
    tick(); drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    check("a_link_so", link_so, 1);
    check("a_link_do", link_do, 64'h0000_0000_0000_00A5);
    tick(); drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    check("a_link_idle", link_so, 0);

    // Contended even-VC arbitration alternates ring, PE, ring, PE.
    for (int r = 0; r < 4; r++) begin
      logic [63:0] rd;
      logic [63:0] pd;
      rd = 64'h0000_0000_0000_1000 + 64'(r);
      pd = 64'h0000_0000_0000_2000 + 64'(r);
      tick(); drive(1'b0, 1'b1, rd, 1'b1, 1'b1); pe_di_even = pd; #1;
      if ((r % 2) == 0) begin
        check("b_ring_ri_ringwin", ring_ri, 1);
        check("b_pe_wr_en_ringwin", pe_wr_en, 0);
        exp_q.push_back(rd);
      end else begin
        check("b_ring_ri_pewin", ring_ri, 0);
        check("b_pe_wr_en_pewin", pe_wr_en, 1);
        exp_q.push_back(pd);
      end
      tick(); drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    end
    pe_di_even = PE_EVEN;

    // Odd-VC ring packet during even fill phase is ignored.
    tick(); drive(1'b0, 1'b1, 64'h8000_0000_0000_0077, 1'b0, 1'b1); #1;
    check("c_ring_ri", ring_ri, 1);
    tick(); drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    check("c_no_even_tx", link_so, 0);
    check("c_odd_empty", pe_ro, 1);
    tick(); drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    check("c_no_odd_tx", link_so, 0);

    // Both slots full with the link stalled across polarity changes.
    tick(); drive(1'b0, 1'b1, 64'h0000_0000_0000_1111, 1'b0, 1'b0); #1;
    exp_q.push_back(64'h0000_0000_0000_1111);
    tick(); drive(1'b1, 1'b1, 64'h8000_0000_0000_2222, 1'b0, 1'b0); #1;
    exp_q.push_back(64'h8000_0000_0000_2222);
    for (int s = 0; s < 6; s++) begin
      tick();
      if ((s % 2) == 0) drive(1'b0, 1'b1, 64'h0000_0000_0000_DEAD, 1'b1, 1'b0);
      else              drive(1'b1, 1'b1, 64'h8000_0000_0000_BEEF, 1'b1, 1'b0);
      #1;
      check("d_stall_link_so", link_so, 0);
      check("d_stall_ring_ri", ring_ri, 0);
      check("d_stall_pe_ro", pe_ro, 0);
      check("d_stall_pe_wr_en", pe_wr_en, 0);
    end
    tick(); drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    tick(); drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    tick(); drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    check("d_drained", link_so, 0);

    // One PE injection per cycle until the counter saturates.
    for (int i = 0; i < 65536; i++) begin
      tick(); drive(i[0], 1'b0, 64'h0, 1'b1, 1'b1); #1;
      if (i == 0) check("e_inj_start", inj_cnt, 16'd2);
      if (i == 65532) check("e_inj_near_sat", inj_cnt, 16'hFFFE);
      check("e_pe_wr_en", pe_wr_en, 1);
      exp_q.push_back(i[0] ? PE_ODD : PE_EVEN);
    end
    tick(); drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    check("e_inj_sat", inj_cnt, 16'hFFFF);
    tick(); drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b1); #1;
    check("e_pe_wr_en_sat", pe_wr_en, 1);
    exp_q.push_back(PE_ODD);
    tick(); drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    check("e_inj_hold", inj_cnt, 16'hFFFF);

    // Reset asserted while a PE packet is granted; the packet is dropped.
    tick(); drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0); reset = 1'b0; #1;
    tick(); drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1); reset = 1'b1; #1;
    check("f_link_so", link_so, 0);
    check("f_link_do", link_do, 0);
    check("f_inj_cnt", inj_cnt, 0);
    check("f_ring_ri", ring_ri, 1);
    check("f_pe_ro", pe_ro, 1);
    check("f_pe_wr_en", pe_wr_en, 0);
    tick(); drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1); #1;
    check("f_odd_empty", link_so, 0);

    tick(); drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0); #3;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_output_port.md
RING_OUTPUT_PORT -- requirements
Module: ring_output_port

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL: polarity  input  1  phase; 0 = fill even slot / transmit odd slot, 1 = fill odd slot / transmit even slot.
REQ-004 SHALL: ring_si  input  1  upstream ring packet valid.
REQ-005 SHALL: ring_di  input  64  upstream ring packet; bit63 = VC (0 even, 1 odd), bit62 = direction.
REQ-006 SHALL: ring_ri  output  1  ready to upstream ring.
REQ-007 SHALL: pe_so  input  1  PE injection buffer offers its active-VC packet (cw direction already qualified).
REQ-008 SHALL: pe_di_even, pe_di_odd  input  64 each  PE injection buffer even/odd slot contents.
REQ-009 SHALL: pe_ro  output  1  ready to PE injection buffer.
REQ-010 SHALL: pe_wr_en  output  1  PE packet taken this cycle; PE buffer clears its slot.
REQ-011 SHALL: link_so  output  1  packet sent to next router this cycle.
REQ-012 SHALL: link_do  output  64  packet to next router.
REQ-013 SHALL: link_ri  input  1  next router ready.
REQ-014 SHALL: inj_cnt  output  16  saturating count of accepted PE packets.

Function
REQ-015 SHALL hold two one-entry slots, slot_even and slot_odd, each with 64-bit data and a full flag.
REQ-016 SHALL define fill VC F = polarity and transmit VC T = !polarity each cycle.
REQ-017 SHALL raise ring request when ring_si = 1 and ring_di[63] = F; ring packets with ring_di[63] != F SHALL be neither requested nor accepted.
REQ-018 SHALL raise PE request when pe_so = 1; PE data = pe_di_even when F = 0, else pe_di_odd.
REQ-019 SHALL assert pe_ro = !full(slot F), independent of pe_so.
REQ-020 SHALL grant slot F only when it is empty: single requester wins; with both requesting, the per-VC round-robin pointer rr_F (0 = ring, 1 = PE) selects the winner.
REQ-021 SHALL, after a contended grant, set rr_F to the loser; uncontended grants leave rr_F unchanged.
REQ-022 SHALL assert ring_ri = !full(slot F) AND NOT (PE request AND rr_F = 1).
REQ-023 SHALL assert pe_wr_en = PE request AND PE granted, combinationally, same cycle.
REQ-024 SHALL write the granted packet into slot F and set full(F) on the clk edge ending the grant cycle (one-cycle latency from accept to slot).
REQ-025 SHALL assert link_so = full(slot T) AND link_ri combinationally; link_do = slot T data; full(T) clears on that edge.
REQ-026 SHALL present link_do = slot T data whenever full(T) = 1, and 64'h0 otherwise.
REQ-027 SHALL never fill and drain the same slot in one cycle; a packet therefore resides >= 1 full polarity phase before transmission.
REQ-028 SHALL increment inj_cnt on each pe_wr_en cycle, saturating at 16'hFFFF.
REQ-029 SHALL preserve slot contents and full flags across polarity changes while the link is stalled (link_ri = 0).

Reset
REQ-030 SHALL, on clk edge with reset = 0: clear both slots' data to 0, full flags to 0, rr_even = rr_odd = 0, inj_cnt = 0; outputs then read link_so = 0, link_do = 0, pe_wr_en = 0, ring_ri = pe_ro = 1.
REQ-031 SHALL let reset override any grant or transmission in the same cycle; a packet accepted that cycle is discarded.

Verification
REQ-032 SHALL cover: polarity = 0, ring_si = 1, ring_di = 64'h0000_0000_0000_00A5, PE idle -> ring_ri = 1, slot_even = A5 next edge; polarity = 1, link_ri = 1 -> link_so = 1, link_do = A5.
REQ-033 SHALL cover: polarity = 0, ring even request and pe_so = 1 both held, slot drained between each -> grants alternate ring, PE, ring, PE; ring_ri = 0 on PE-win cycles.
REQ-034 SHALL cover: polarity = 0, ring_di[63] = 1 with ring_si = 1 -> ring_ri may be 1 but no write to either slot; slot_odd unchanged.
REQ-035 SHALL cover: link_ri = 0 for 6 cycles with both slots full, polarity toggling -> no link_so, pe_ro = ring_ri = 0, data intact; link_ri = 1 -> slots drain in polarity order.
REQ-036 SHALL cover: 65536 PE injections -> inj_cnt = 16'hFFFF and holds; reset = 0 mid-grant -> all state at reset values next edge, inj_cnt = 0.
